// File: rtl/booth_radix4_seq.sv
// booth_radix4_seq
//   Sequential signed radix-4 Booth multiplier datapath. It exposes the
//   current 3-bit multiplier window and consumes the add/noop/dbl controls
//   returned by an external combinational Booth decoder in the same cycle.
//   A WIDTH x WIDTH signed multiply takes WIDTH/2 RUN steps plus one DONE
//   cycle.
//
// Ports
//   clock           rising-edge clock
//   reset           asynchronous active-high reset
//   start           operands valid, sampled only in IDLE
//   multiplicand    signed M (WIDTH)
//   multiplier      signed Q (WIDTH)
//   lsb_multiplier  current Booth window {P[2],P[1],P[0]}, 3'b000 outside RUN
//   add/noop/dbl    decoded Booth controls from the external decoder
//   busy            high while stepping (RUN)
//   done            one-cycle pulse when product/ovf are valid
//   product         signed M*Q (2*WIDTH), held until the next DONE
//   ovf             product does not fit in WIDTH signed bits
module booth_radix4_seq #(
  parameter int WIDTH = 32
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic [2:0]           lsb_multiplier,
  input  logic                 add,
  input  logic                 noop,
  input  logic                 dbl,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product,
  output logic                 ovf
);

  // The accumulator field needs two guard bits so that +/-2M partial sums
  // never wrap; P is therefore {A, Q, 1'b0} = (WIDTH+2)+WIDTH+1 bits.
  localparam int AW    = WIDTH + 2;
  localparam int PW    = AW + WIDTH + 1;
  localparam int STEPS = WIDTH / 2;
  localparam int CW    = $clog2(STEPS) + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t               state_reg, state_next;
  logic [WIDTH-1:0]     m_reg, m_next;
  logic [PW-1:0]        p_reg, p_next;
  logic [CW-1:0]        cnt_reg, cnt_next;
  logic [2*WIDTH-1:0]   product_reg, product_next;
  logic                 ovf_reg, ovf_next;

  logic [AW-1:0]        m_ext;
  logic [AW-1:0]        magnitude;
  logic [AW-1:0]        addend;
  logic [AW-1:0]        acc_sum;
  logic [PW-1:0]        shifted;
  logic [2*WIDTH-1:0]   prod_cand;
  logic [WIDTH:0]       prod_top;
  logic                 ovf_cand;

  // Datapath for one Booth step: select the addend from the decoder's
  // controls, accumulate into the upper field, then arithmetic-shift by 2.
  always_comb begin
    m_ext     = {{2{m_reg[WIDTH-1]}}, m_reg};
    magnitude = dbl ? {m_ext[AW-2:0], 1'b0} : m_ext;
    // noop wins over add/dbl so an inconsistent decoder output adds nothing.
    if (noop) begin
      addend = '0;
    end else if (add) begin
      addend = magnitude;
    end else begin
      addend = -magnitude;
    end
    acc_sum   = p_reg[PW-1 -: AW] + addend;
    shifted   = $signed({acc_sum, p_reg[WIDTH:0]}) >>> 2;
    prod_cand = shifted[2*WIDTH:1];
    // Fits in WIDTH signed bits only when the sign bit of the low half
    // matches every bit above it.
    prod_top  = prod_cand[2*WIDTH-1:WIDTH-1];
    ovf_cand  = ~((&prod_top) | ~(|prod_top));
  end

  // Next-state and register-update logic.
  always_comb begin
    state_next   = state_reg;
    m_next       = m_reg;
    p_next       = p_reg;
    cnt_next     = cnt_reg;
    product_next = product_reg;
    ovf_next     = ovf_reg;
    unique case (state_reg)
      IDLE: begin
        if (start) begin
          m_next     = multiplicand;
          p_next     = {{AW{1'b0}}, multiplier, 1'b0};
          cnt_next   = '0;
          state_next = RUN;
        end
      end
      RUN: begin
        p_next   = shifted;
        cnt_next = cnt_reg + CW'(1);
        if (cnt_reg == CW'(STEPS - 1)) begin
          // Last step: capture the result so it is visible in the DONE cycle.
          product_next = prod_cand;
          ovf_next     = ovf_cand;
          state_next   = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg   <= IDLE;
      m_reg       <= '0;
      p_reg       <= '0;
      cnt_reg     <= '0;
      product_reg <= '0;
      ovf_reg     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      m_reg       <= m_next;
      p_reg       <= p_next;
      cnt_reg     <= cnt_next;
      product_reg <= product_next;
      ovf_reg     <= ovf_next;
    end
  end

  assign busy           = (state_reg == RUN);
  assign done           = (state_reg == DONE);
  assign lsb_multiplier = busy ? p_reg[2:0] : 3'b000;
  assign product        = product_reg;
  assign ovf            = ovf_reg;

endmodule
